fp_special_case_pipe: RTL and testbench
=======================================

Name: fp_special_case_pipe

Overview:
- Parametrised successor to the adder's Stage 1.5 special-case detector; sits between operand unpack (Stage 1) and alignment (Stage 2).
- Classifies NaN, Inf and zero operands and produces the IEEE result directly on a bypass flag. Raises an invalid flag.
- Adds generic exponent/mantissa widths, rounding-mode-aware zero sign, NaN quieting, a transaction tag, and a valid/ready handshake with a 2-entry skid buffer so stalls from Stage 2 lose no data.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (operand mantissa inputs are MAN_W+1 bits incl. hidden bit).
- TAG_W, 4, width of opaque transaction tag carried alongside data.
- QNAN_CANON, 1, 1: every NaN result is canonical qNaN; 0: propagate quieted payload of first NaN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream operand set valid.
- in_ready  out  1  block can accept; registered.
- in_sign_a, in_sign_b_eff  in  1 each  operand A sign, effective (post-op) B sign.
- in_exp_a, in_exp_b  in  EXP_W each  biased exponents.
- in_man_a, in_man_b  in  MAN_W+1 each  mantissas incl. hidden bit; fraction = [MAN_W-1:0].
- in_exp_diff  in  EXP_W  |exp_a-exp_b| from Stage 1.
- in_a_bigger  in  1  A magnitude >= B.
- in_rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP.
- in_tag  in  TAG_W  transaction tag.
- out_valid  out  1  output stage holds valid data.
- out_ready  in  1  downstream accepts.
- out_bypass  out  1  result is final; Stage 2+ must not compute.
- out_result  out  1+EXP_W+MAN_W  final IEEE word when out_bypass=1, else 0.
- out_invalid  out  1  IEEE invalid-operation flag.
- out_sign_a, out_sign_b, out_exp_a, out_exp_b, out_man_a, out_man_b, out_exp_diff, out_a_bigger, out_rm, out_tag  out  matching widths  registered pass-through of the inputs.

Behaviour:
- Classification per operand, F = fraction: zero = exp==0 && F==0; inf = exp==all-ones && F==0; nan = exp==all-ones && F!=0; sNaN = nan && F[MAN_W-1]==0. Subnormals (exp==0, F!=0) are not special; they go down the main path.
- Priority: NaN > Inf > Zero > normal.
- NaN:
  - Bypass=1.
  - QNAN_CANON=1: result {0, all-ones, 1, zeros}.
  - QNAN_CANON=0: take A if A is NaN, else B; keep that operand's sign and fraction, force F[MAN_W-1]=1.
  - invalid=1 if either operand is sNaN.
- Inf:
  - Both Inf with sign_a != sign_b_eff: canonical qNaN, invalid=1.
  - Both Inf, same sign: {sign_a, Inf}.
  - Single Inf: that operand's Inf, using sign_b_eff for B.
- Zero:
  - Both zero, sign_a == sign_b_eff: sign_a zero.
  - Both zero, signs differ: +0, except -0 when rm==RDN.
  - A zero only: {sign_b_eff, exp_b, F_b}.
  - B zero only: {sign_a, exp_a, F_a}.
- Pass-through fields are registered regardless of bypass.
- Handshake:
  - Accept when in_valid && in_ready.
  - Output stage loads when empty or out_ready.
  - If the output stage is held (out_valid && !out_ready) and an item is accepted, the item goes to the skid entry.
  - in_ready = !skid_full, registered. When the output stage is consumed, skid moves to output in the same edge.
- Latency 1 cycle unstalled; throughput 1/cycle; order preserved; no drop or duplication. Output data is stable while out_valid && !out_ready.
- Simultaneous consume and accept with skid full: skid moves to output, in_ready rises the next cycle. New data is never taken while skid is full.
- Reset (synchronous): out_valid=0, skid empty, all output data/flag registers 0, in_ready=0 during rst and 1 the cycle after rst deasserts. Reset mid-stall discards both held entries.

Test Plan:
- A=+1.0 (0x3F800000), B=+0, in_valid pulse, out_ready=1 -> next cycle out_valid=1, bypass=1, result 0x3F800000, invalid=0.
- A=+Inf, B=-Inf eff (0x7F800000/0xFF800000) -> result 0x7FC00000, invalid=1.
- A=sNaN 0x7F800001, B=1.0, QNAN_CANON=0 -> result 0x7FC00001, invalid=1; QNAN_CANON=1 -> 0x7FC00000.
- A=+0, B=-0 eff, rm=RDN -> 0x80000000; same operands rm=RNE -> 0x00000000. A=B=-0 -> 0x80000000.
- Stream tags 1..6 with out_ready low for 3 cycles mid-stream -> in_ready drops after 2 held entries; tags emerge 1..6 in order, none lost or repeated.
- Assert rst while skid full -> next cycle out_valid=0, all outputs 0; cycle after, in_ready=1 and a new item emerges with 1-cycle latency.

Source files
------------

// File: rtl/fp_special_case_pipe.sv
// Special-case detector between operand unpack and alignment.
// Resolves NaN/Inf/zero operands to a final IEEE word behind a skid-buffered handshake.
module fp_special_case_pipe #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int TAG_W      = 4,
    parameter int QNAN_CANON = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign_a,
    input  logic                   in_sign_b_eff,
    input  logic [EXP_W-1:0]       in_exp_a,
    input  logic [EXP_W-1:0]       in_exp_b,
    input  logic [MAN_W:0]         in_man_a,
    input  logic [MAN_W:0]         in_man_b,
    input  logic [EXP_W-1:0]       in_exp_diff,
    input  logic                   in_a_bigger,
    input  logic [1:0]             in_rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_bypass,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_invalid,
    output logic                   out_sign_a,
    output logic                   out_sign_b,
    output logic [EXP_W-1:0]       out_exp_a,
    output logic [EXP_W-1:0]       out_exp_b,
    output logic [MAN_W:0]         out_man_a,
    output logic [MAN_W:0]         out_man_b,
    output logic [EXP_W-1:0]       out_exp_diff,
    output logic                   out_a_bigger,
    output logic [1:0]             out_rm,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int RW = 1 + EXP_W + MAN_W;
    localparam int PW = 1 + RW + 1 + 2 + 3 * EXP_W + 2 * (MAN_W + 1) + 1 + 2 + TAG_W;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [RW-1:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [1:0]       RM_RDN   = 2'b10;

    logic [MAN_W-1:0] w_frac_a;
    logic [MAN_W-1:0] w_frac_b;
    logic             w_a_zero, w_a_inf, w_a_nan, w_a_snan;
    logic             w_b_zero, w_b_inf, w_b_nan, w_b_snan;
    logic             w_bypass;
    logic             w_invalid;
    logic [RW-1:0]    w_result;
    logic [PW-1:0]    w_pl;
    logic             w_acc;
    logic             w_out_free;

    logic             r_out_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [PW-1:0]    r_out_pl;
    logic [PW-1:0]    r_skid_pl;

    assign w_frac_a = in_man_a[MAN_W-1:0];
    assign w_frac_b = in_man_b[MAN_W-1:0];

    assign w_a_zero = (in_exp_a == '0) && (w_frac_a == '0);
    assign w_a_inf  = (in_exp_a == EXP_ONES) && (w_frac_a == '0);
    assign w_a_nan  = (in_exp_a == EXP_ONES) && (w_frac_a != '0);
    assign w_a_snan = w_a_nan && !w_frac_a[MAN_W-1];

    assign w_b_zero = (in_exp_b == '0) && (w_frac_b == '0);
    assign w_b_inf  = (in_exp_b == EXP_ONES) && (w_frac_b == '0);
    assign w_b_nan  = (in_exp_b == EXP_ONES) && (w_frac_b != '0);
    assign w_b_snan = w_b_nan && !w_frac_b[MAN_W-1];

    always_comb begin
        w_bypass  = 1'b1;
        w_invalid = 1'b0;
        w_result  = '0;
        if (w_a_nan || w_b_nan) begin
            w_invalid = w_a_snan || w_b_snan;
            if (QNAN_CANON != 0)
                w_result = QNAN;
            else if (w_a_nan)
                w_result = {in_sign_a, in_exp_a, 1'b1, w_frac_a[MAN_W-2:0]};
            else
                w_result = {in_sign_b_eff, in_exp_b, 1'b1, w_frac_b[MAN_W-2:0]};
        end else if (w_a_inf && w_b_inf) begin
            // Opposite infinities cancel: the classic inf - inf invalid case
            if (in_sign_a != in_sign_b_eff) begin
                w_result  = QNAN;
                w_invalid = 1'b1;
            end else begin
                w_result = {in_sign_a, EXP_ONES, {MAN_W{1'b0}}};
            end
        end else if (w_a_inf) begin
            w_result = {in_sign_a, EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_b_inf) begin
            w_result = {in_sign_b_eff, EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_a_zero && w_b_zero) begin
            if (in_sign_a == in_sign_b_eff)
                w_result = {in_sign_a, {(RW-1){1'b0}}};
            else
                w_result = {(in_rm == RM_RDN), {(RW-1){1'b0}}};
        end else if (w_a_zero) begin
            w_result = {in_sign_b_eff, in_exp_b, w_frac_b};
        end else if (w_b_zero) begin
            w_result = {in_sign_a, in_exp_a, w_frac_a};
        end else begin
            w_bypass = 1'b0;
        end
    end

    assign w_pl = {w_bypass, w_result, w_invalid,
                   in_sign_a, in_sign_b_eff,
                   in_exp_a, in_exp_b,
                   in_man_a, in_man_b,
                   in_exp_diff, in_a_bigger,
                   in_rm, in_tag};

    assign w_acc      = in_valid && r_in_ready;
    assign w_out_free = !r_out_valid || out_ready;

    // in_ready mirrors "skid not full" one edge late, so no accept can hit a full skid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_pl     <= '0;
            r_skid_pl    <= '0;
        end else if (w_out_free) begin
            r_in_ready <= 1'b1;
            if (r_skid_valid) begin
                r_out_pl     <= r_skid_pl;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_acc;
                if (w_acc)
                    r_out_pl <= w_pl;
            end
        end else if (w_acc) begin
            r_skid_pl    <= w_pl;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end else begin
            r_in_ready <= !r_skid_valid;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;

    assign {out_bypass, out_result, out_invalid,
            out_sign_a, out_sign_b,
            out_exp_a, out_exp_b,
            out_man_a, out_man_b,
            out_exp_diff, out_a_bigger,
            out_rm, out_tag} = r_out_pl;

endmodule

// File: tb/tb_fp_special_case_pipe.sv
// Bench for fp_special_case_pipe: canonical and payload-propagating NaN instances
// driven in parallel, checked against a float-level reference model.
module tb_fp_special_case_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sign_a, in_sign_b_eff, in_a_bigger;
    logic [7:0]  in_exp_a, in_exp_b, in_exp_diff;
    logic [23:0] in_man_a, in_man_b;
    logic [1:0]  in_rm;
    logic [3:0]  in_tag;
    logic        out_ready;

    logic        c_in_ready, c_out_valid, c_bypass, c_invalid;
    logic [31:0] c_result;
    logic        c_sa, c_sb, c_ab;
    logic [7:0]  c_ea, c_eb, c_ed;
    logic [23:0] c_ma, c_mb;
    logic [1:0]  c_rm;
    logic [3:0]  c_tag;

    logic        p_in_ready, p_out_valid, p_bypass, p_invalid;
    logic [31:0] p_result;
    logic        p_sa, p_sb, p_ab;
    logic [7:0]  p_ea, p_eb, p_ed;
    logic [23:0] p_ma, p_mb;
    logic [1:0]  p_rm;
    logic [3:0]  p_tag;

    logic [114:0] c_bundle;
    assign c_bundle = {c_bypass, c_result, c_invalid, c_sa, c_sb, c_ea, c_eb,
                       c_ma, c_mb, c_ed, c_ab, c_rm, c_tag};

    typedef struct {
        logic [31:0] rc;
        logic [31:0] rp;
        logic        byp;
        logic        inv;
        logic [80:0] pass;
    } exp_t;

    exp_t         q[$];
    logic [3:0]   obs[$];
    int           n_chk = 0;
    int           n_fail = 0;
    logic         held = 1'b0;
    logic [114:0] held_snap;

    always #5 clk = ~clk;

    fp_special_case_pipe #(.QNAN_CANON(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_sign_a(in_sign_a), .in_sign_b_eff(in_sign_b_eff),
        .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
        .in_man_a(in_man_a), .in_man_b(in_man_b),
        .in_exp_diff(in_exp_diff), .in_a_bigger(in_a_bigger),
        .in_rm(in_rm), .in_tag(in_tag),
        .out_valid(c_out_valid), .out_ready(out_ready),
        .out_bypass(c_bypass), .out_result(c_result), .out_invalid(c_invalid),
        .out_sign_a(c_sa), .out_sign_b(c_sb), .out_exp_a(c_ea), .out_exp_b(c_eb),
        .out_man_a(c_ma), .out_man_b(c_mb), .out_exp_diff(c_ed),
        .out_a_bigger(c_ab), .out_rm(c_rm), .out_tag(c_tag)
    );

    fp_special_case_pipe #(.QNAN_CANON(0)) u_p (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p_in_ready),
        .in_sign_a(in_sign_a), .in_sign_b_eff(in_sign_b_eff),
        .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
        .in_man_a(in_man_a), .in_man_b(in_man_b),
        .in_exp_diff(in_exp_diff), .in_a_bigger(in_a_bigger),
        .in_rm(in_rm), .in_tag(in_tag),
        .out_valid(p_out_valid), .out_ready(out_ready),
        .out_bypass(p_bypass), .out_result(p_result), .out_invalid(p_invalid),
        .out_sign_a(p_sa), .out_sign_b(p_sb), .out_exp_a(p_ea), .out_exp_b(p_eb),
        .out_man_a(p_ma), .out_man_b(p_mb), .out_exp_diff(p_ed),
        .out_a_bigger(p_ab), .out_rm(p_rm), .out_tag(p_tag)
    );

    // Reference: operate on whole single-precision words
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] rm, input bit canon,
                                  output logic byp, output logic inv,
                                  output logic [31:0] r);
        bit an, bn, ai, bi, az, bz, as, bs;
        an = a[30:0] > 31'h7F800000;
        bn = b[30:0] > 31'h7F800000;
        ai = a[30:0] == 31'h7F800000;
        bi = b[30:0] == 31'h7F800000;
        az = a[30:0] == 31'h0;
        bz = b[30:0] == 31'h0;
        as = an && !a[22];
        bs = bn && !b[22];
        byp = 1'b1;
        inv = 1'b0;
        r   = 32'h0;
        if (an || bn) begin
            inv = as || bs;
            r = canon ? 32'h7FC00000 : ((an ? a : b) | 32'h00400000);
        end else if (ai && bi) begin
            if (a[31] != b[31]) begin
                r = 32'h7FC00000;
                inv = 1'b1;
            end else begin
                r = a;
            end
        end else if (ai) r = a;
        else if (bi) r = b;
        else if (az && bz) r = (a[31] == b[31]) ? a : (rm == 2'b10 ? 32'h80000000 : 32'h0);
        else if (az) r = b;
        else if (bz) r = a;
        else byp = 1'b0;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 3))
            0: e = 8'h00;
            1: e = 8'hFF;
            default: e = 8'($urandom_range(0, 255));
        endcase
        case ($urandom_range(0, 4))
            0, 1: f = 23'h0;
            2: f = 23'h1;
            3: f = 23'($urandom) | 23'h400000;
            default: f = 23'($urandom) & 23'h3FFFFF;
        endcase
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    task automatic drive_ops(input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] rm);
        in_sign_a     = a[31];
        in_exp_a      = a[30:23];
        in_man_a      = {(a[30:23] != 8'h0), a[22:0]};
        in_sign_b_eff = b[31];
        in_exp_b      = b[30:23];
        in_man_b      = {(b[30:23] != 8'h0), b[22:0]};
        in_rm         = rm;
        in_exp_diff   = 8'($urandom);
        in_a_bigger   = 1'($urandom);
    endtask

    // One clock: check output consumed at this edge, record input accepted at this edge
    task automatic step();
        exp_t        e;
        logic [31:0] a, b;
        @(negedge clk);
        if (held) begin
            n_chk++;
            if (c_bundle !== held_snap) begin
                n_fail++;
                $display("FAIL hold_stable: got %h want %h", c_bundle, held_snap);
            end
        end
        if (c_out_valid && out_ready) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_output: tag %0d with empty model queue", c_tag);
            end else begin
                e = q.pop_front();
                if ({c_bypass, c_result, c_invalid, c_sa, c_sb, c_ea, c_eb, c_ma, c_mb,
                     c_ed, c_ab, c_rm, c_tag} !== {e.byp, e.rc, e.inv, e.pass}) begin
                    n_fail++;
                    $display("FAIL canon_out: got byp=%b res=%h inv=%b pass=%h want byp=%b res=%h inv=%b pass=%h",
                             c_bypass, c_result, c_invalid,
                             {c_sa, c_sb, c_ea, c_eb, c_ma, c_mb, c_ed, c_ab, c_rm, c_tag},
                             e.byp, e.rc, e.inv, e.pass);
                end
                n_chk++;
                if ({p_out_valid, p_bypass, p_invalid, p_result} !== {1'b1, e.byp, e.inv, e.rp}) begin
                    n_fail++;
                    $display("FAIL prop_out: got v=%b byp=%b inv=%b res=%h want v=1 byp=%b inv=%b res=%h",
                             p_out_valid, p_bypass, p_invalid, p_result, e.byp, e.inv, e.rp);
                end
                obs.push_back(c_tag);
            end
        end
        held      = c_out_valid && !out_ready;
        held_snap = c_bundle;
        if (in_valid && c_in_ready) begin
            a = {in_sign_a, in_exp_a, in_man_a[22:0]};
            b = {in_sign_b_eff, in_exp_b, in_man_b[22:0]};
            model(a, b, in_rm, 1'b1, e.byp, e.inv, e.rc);
            model(a, b, in_rm, 1'b0, e.byp, e.inv, e.rp);
            e.pass = {in_sign_a, in_sign_b_eff, in_exp_a, in_exp_b, in_man_a, in_man_b,
                      in_exp_diff, in_a_bigger, in_rm, in_tag};
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_tag = 4'h0;
        drive_ops(32'h0, 32'h0, 2'b00);
        @(posedge clk);
        #1;
        n_chk++;
        if ({c_out_valid, c_in_ready, c_bundle} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ready=%b data=%h want all 0",
                     c_out_valid, c_in_ready, c_bundle);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_chk++;
        if ({c_in_ready, c_out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valid=%b want ready=1 valid=0",
                     c_in_ready, c_out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va[8]   = '{32'h3F800000, 32'h7F800000, 32'h7F800001, 32'h00000000,
                                 32'h00000000, 32'h80000000, 32'h00000001, 32'h3F800000};
        logic [31:0] vb[8]   = '{32'h00000000, 32'hFF800000, 32'h3F800000, 32'h80000000,
                                 32'h80000000, 32'h80000000, 32'h3F800000, 32'hFFC12345};
        logic [1:0]  vrm[8]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01};
        logic [31:0] vrc[8]  = '{32'h3F800000, 32'h7FC00000, 32'h7FC00000, 32'h80000000,
                                 32'h00000000, 32'h80000000, 32'h00000000, 32'h7FC00000};
        logic [31:0] vrp[8]  = '{32'h3F800000, 32'h7FC00000, 32'h7FC00001, 32'h80000000,
                                 32'h00000000, 32'h80000000, 32'h00000000, 32'hFFC12345};
        logic        vbyp[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        vinv[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_ops(va[i], vb[i], vrm[i]);
            in_tag = 4'(i);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n_chk++;
            if ({c_out_valid, c_bypass, c_invalid, c_result, p_result, c_tag} !==
                {1'b1, vbyp[i], vinv[i], vrc[i], vrp[i], 4'(i)}) begin
                n_fail++;
                $display("FAIL directed_%0d: got v=%b byp=%b inv=%b res=%h/%h want v=1 byp=%b inv=%b res=%h/%h",
                         i, c_out_valid, c_bypass, c_invalid, c_result, p_result,
                         vbyp[i], vinv[i], vrc[i], vrp[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall_order();
        int  k = 1;
        bit  saw_low = 1'b0;
        bit  done = 1'b0;
        q.delete();
        obs.delete();
        held = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            in_valid = (k <= 6);
            in_tag = 4'(k);
            drive_ops(rand_word(), rand_word(), 2'($urandom));
            out_ready = !(cyc >= 2 && cyc <= 4);
            if (!c_in_ready && !saw_low) begin
                saw_low = 1'b1;
                n_chk++;
                if (q.size() != 2) begin
                    n_fail++;
                    $display("FAIL stall_depth: in_ready low with %0d held, want 2", q.size());
                end
            end
            if (in_valid && c_in_ready) k++;
            step();
            done = (k > 6) && (obs.size() == 6);
        end
        in_valid = 1'b0;
        n_chk++;
        if (!saw_low || !done) begin
            n_fail++;
            $display("FAIL stall_progress: saw_low=%b done=%b want 1/1", saw_low, done);
        end
        n_chk++;
        if (obs.size() != 6) begin
            n_fail++;
            $display("FAIL stall_count: got %0d tags want 6", obs.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_chk++;
                if (obs[i] !== 4'(i + 1)) begin
                    n_fail++;
                    $display("FAIL stall_order_%0d: got tag %0d want %0d", i, obs[i], i + 1);
                end
            end
        end
    endtask

    task automatic test_random();
        q.delete();
        held = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            in_tag = 4'($urandom);
            drive_ops(rand_word(), rand_word(), 2'($urandom));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && q.size() != 0; cyc++) step();
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: %0d items never emerged", q.size());
        end
    endtask

    task automatic test_reset_midstall();
        q.delete();
        held = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_tag = 4'(i + 8);
            drive_ops(rand_word(), rand_word(), 2'($urandom));
            step();
        end
        n_chk++;
        if ({c_in_ready, c_out_valid, q.size() == 2} !== 3'b011) begin
            n_fail++;
            $display("FAIL midstall_full: ready=%b valid=%b held=%0d want 0/1/2",
                     c_in_ready, c_out_valid, q.size());
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({c_out_valid, c_in_ready, c_bundle} !== '0) begin
            n_fail++;
            $display("FAIL midstall_reset: valid=%b ready=%b data=%h want all 0",
                     c_out_valid, c_in_ready, c_bundle);
        end
        q.delete();
        held = 1'b0;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({c_in_ready, c_out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL midstall_release: ready=%b valid=%b want 1/0", c_in_ready, c_out_valid);
        end
        in_valid = 1'b1;
        in_tag = 4'hC;
        drive_ops(32'h7F800000, 32'h40000000, 2'b00);
        step();
        in_valid = 1'b0;
        n_chk++;
        if ({c_out_valid, c_tag} !== {1'b1, 4'hC}) begin
            n_fail++;
            $display("FAIL midstall_latency: valid=%b tag=%h want 1/c", c_out_valid, c_tag);
        end
        step();
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL midstall_drain: %0d items left", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall_order();
        test_random();
        test_reset_midstall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
